serial_frame_rx: RTL and testbench
==================================

Name: serial_frame_rx

Overview:
- Serial frame receiver, built as an enabled DFF-based shift register with a control FSM.
- Samples a 1-bit serial line on Clock edges where en=1, detects a start bit and shifts in WIDTH data bits LSB-first.
- Optionally checks a parity bit, then checks the stop bit.
- Presents the assembled word with a one-cycle valid pulse and error flags; it is the receiving end of the CA3 serial frame link.

Parameters:
- WIDTH, 8, number of data bits per frame (2..16).
- PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.
- PARITY_ODD, 0, 0 = even parity expected; 1 = odd parity expected.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets immediately, independent of Clock).
- en  input  1  sample enable; the FSM advances and serial_in is sampled only on edges with en=1.
- serial_in  input  1  serial line; idles high.
- data_out  output  WIDTH  last received word; holds until the next frame completes.
- valid  output  1  one-Clock-cycle pulse when a frame completes with a correct stop bit.
- parity_err  output  1  parity result of the last completed frame; holds with data_out.
- frame_err  output  1  one-Clock-cycle pulse when the stop bit is sampled as 0.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; shift register=0; bit counter=0; data_out=0; valid=0; parity_err=0; frame_err=0; busy=0.
- Release of rst takes effect at the next rising Clock edge.
- States: IDLE, DATA, PARITY, STOP.
  - IDLE: on an en=1 edge with serial_in=0 (start bit), go to DATA and clear the counter; serial_in=1 stays in IDLE.
  - DATA: each en=1 edge shifts serial_in into the shift register at bit [WIDTH-1], shifting right, so the first bit lands at [0] once complete. Counter increments.
  - DATA exit: after the WIDTH-th data bit, go to PARITY if PARITY_EN=1, else to STOP.
  - PARITY: the en=1 edge samples the parity bit, then go to STOP.
    - Even mode: error if XOR(data) != parity bit.
    - Odd mode: error if XOR(data) == parity bit.
  - STOP: the en=1 edge samples the stop bit and returns to IDLE. busy deasserts on that same edge.
    - Stop=1: data_out <= shift register; parity_err <= computed error (0 when PARITY_EN=0); valid=1 for exactly the following Clock cycle.
    - Stop=0: frame_err=1 for exactly the following Clock cycle; data_out and parity_err are unchanged; valid stays 0.
- Latency: valid asserts in the cycle right after the edge that samples the stop bit. A frame occupies 1+WIDTH+PARITY_EN+1 en=1 edges.
- en=0 freezes the FSM, counter and shift register; the line is ignored. valid and frame_err still drop after one Clock cycle; pulses are never stretched by en.
- Back-to-back frames: a start bit sampled on the first en=1 edge after STOP is accepted, with no idle bit required.
- A glitch or low level on serial_in while in IDLE is treated as a start bit; there is no false-start filtering.
- Reset mid-frame: the partial frame is discarded, all outputs are cleared, and there is no valid pulse.
- Counter width: $clog2(WIDTH)+1 bits; no wrap-around within a frame.

Test Plan:
- Reset, then WIDTH=8, even parity, en=1 every cycle; send 0 (start), 1,0,1,0,0,1,0,1 (0xA5 LSB-first), 0 (parity), 1 (stop) -> data_out=8'hA5, parity_err=0, valid high exactly one cycle after the 11th edge, busy low.
- Same frame with parity bit 1 -> valid pulse, data_out=8'hA5, parity_err=1.
- Frame 0x3C with stop bit 0 -> frame_err pulses one cycle; valid=0; data_out keeps the previous value 8'hA5.
- Frame 0x81 with en toggling 1,0,1,0 -> same result as continuous en; completes after 11 en=1 edges; valid still one Clock wide.
- Pull rst low after 4 data bits of a frame -> all outputs 0 immediately (asynchronous); the next full frame 0x5A is received correctly.
- Two back-to-back frames 0x12 then 0xFE with no idle bit between them -> two valid pulses, data_out 8'h12 then 8'hFE.

Source files
------------

// File: rtl/serial_frame_rx.sv
// serial_frame_rx - receiving end of a start/data/parity/stop serial link.
//
// Samples serial_in only on Clock edges with en=1. A low level in IDLE is
// taken as a start bit, then WIDTH data bits are shifted in LSB-first,
// an optional parity bit is checked, and the stop bit decides whether the
// frame is delivered (valid pulse) or rejected (frame_err pulse).
//
// Ports:
//   Clock      in   system clock, rising edge
//   rst        in   asynchronous active-low reset
//   en         in   sample enable; FSM and datapath frozen when 0
//   serial_in  in   serial line, idles high
//   data_out   out  last good word, held until the next good frame
//   valid      out  one-cycle pulse after a good stop bit
//   parity_err out  parity result of the last delivered frame
//   frame_err  out  one-cycle pulse after a stop bit sampled as 0
//   busy       out  FSM not in IDLE
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | line idle, waiting for a low start bit
// S_DATA   | shifting in WIDTH data bits, LSB first
// S_PARITY | sampling the parity bit (only when PARITY_EN=1)
// S_STOP   | sampling the stop bit, deliver or flag the frame

module serial_frame_rx #(
    parameter int WIDTH      = 8,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic             Clock,
    input  logic             rst,
    input  logic             en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid,
    output logic             parity_err,
    output logic             frame_err,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] shift_q;
    logic [CW-1:0]    cnt_q;
    logic             perr_pend_q;
    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic             perr_q;
    logic             ferr_q;

    logic [WIDTH-1:0] shift_d;
    logic             perr_d;

    // Right shift: the first bit received ends up at [0] after WIDTH bits.
    assign shift_d = {serial_in, shift_q[WIDTH-1:1]};
    // Even mode flags XOR(data)^p = 1; odd mode flags XOR(data)^p = 0.
    assign perr_d  = (^shift_q) ^ serial_in ^ PARITY_ODD;

    always_ff @(posedge Clock or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            perr_pend_q <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            // Pulses last exactly one Clock regardless of en.
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            if (en) begin
                unique case (state_q)
                    S_IDLE: begin
                        if (!serial_in) begin
                            state_q     <= S_DATA;
                            cnt_q       <= '0;
                            perr_pend_q <= 1'b0;
                        end
                    end
                    S_DATA: begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 1'b1;
                        if (cnt_q == CW'(WIDTH - 1)) begin
                            state_q <= PARITY_EN ? S_PARITY : S_STOP;
                        end
                    end
                    S_PARITY: begin
                        perr_pend_q <= perr_d;
                        state_q     <= S_STOP;
                    end
                    S_STOP: begin
                        state_q <= S_IDLE;
                        if (serial_in) begin
                            data_q  <= shift_q;
                            perr_q  <= perr_pend_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q  <= 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign data_out   = data_q;
    assign valid      = valid_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
module tb_serial_frame_rx;

    logic       Clock;
    logic       rst;
    logic       en;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid;
    logic       parity_err;
    logic       frame_err;
    logic       busy;

    int n_chk;
    int n_fail;

    serial_frame_rx #(
        .WIDTH     (8),
        .PARITY_EN (1'b1),
        .PARITY_ODD(1'b0)
    ) dut (
        .Clock     (Clock),
        .rst       (rst),
        .en        (en),
        .serial_in (serial_in),
        .data_out  (data_out),
        .valid     (valid),
        .parity_err(parity_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Sends start, 8 data bits LSB-first, parity, stop. With gap=1 every
    // en=1 edge is followed by an en=0 edge carrying the inverted bit,
    // which must be ignored. Returns just after the stop-bit edge.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic stop, input bit gap);
        logic [10:0] bits;
        bits = {stop, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            serial_in = bits[i];
            en        = 1'b1;
            tick();
            if (i == 0) chk("busy_after_start", {31'd0, busy}, 32'd1);
            if (i == 9) chk("no_valid_before_stop", {31'd0, valid}, 32'd0);
            if (gap && i < 10) begin
                serial_in = ~bits[i];
                en        = 1'b0;
                tick();
            end
        end
    endtask

    task automatic idle_cycle();
        serial_in = 1'b1;
        en        = 1'b1;
        tick();
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        rst       = 1'b0;
        en        = 1'b0;
        serial_in = 1'b1;
        #12;
        chk("rst_data",  {24'd0, data_out}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        chk("rst_perr",  {31'd0, parity_err}, 32'd0);
        chk("rst_ferr",  {31'd0, frame_err}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b1;
        tick();
        idle_cycle();
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // 0xA5, correct even parity 0
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        chk("f1_valid", {31'd0, valid}, 32'd1);
        chk("f1_data",  {24'd0, data_out}, 32'hA5);
        chk("f1_perr",  {31'd0, parity_err}, 32'd0);
        chk("f1_ferr",  {31'd0, frame_err}, 32'd0);
        chk("f1_busy",  {31'd0, busy}, 32'd0);
        idle_cycle();
        chk("f1_valid_drop", {31'd0, valid}, 32'd0);

        // 0xA5, wrong parity bit
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        chk("f2_valid", {31'd0, valid}, 32'd1);
        chk("f2_data",  {24'd0, data_out}, 32'hA5);
        chk("f2_perr",  {31'd0, parity_err}, 32'd1);
        idle_cycle();

        // 0x3C, bad stop bit: data_out and parity_err keep previous values
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        chk("f3_ferr",  {31'd0, frame_err}, 32'd1);
        chk("f3_valid", {31'd0, valid}, 32'd0);
        chk("f3_data",  {24'd0, data_out}, 32'hA5);
        chk("f3_perr",  {31'd0, parity_err}, 32'd1);
        chk("f3_busy",  {31'd0, busy}, 32'd0);
        idle_cycle();
        chk("f3_ferr_drop", {31'd0, frame_err}, 32'd0);

        // 0x81 with en toggling
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        chk("f4_valid", {31'd0, valid}, 32'd1);
        chk("f4_data",  {24'd0, data_out}, 32'h81);
        chk("f4_perr",  {31'd0, parity_err}, 32'd0);
        en = 1'b0;
        tick();
        chk("f4_valid_drop_en0", {31'd0, valid}, 32'd0);

        // Reset after start + 4 data bits of 0x5A
        serial_in = 1'b0; en = 1'b1; tick();
        serial_in = 1'b0; tick();
        serial_in = 1'b1; tick();
        serial_in = 1'b0; tick();
        serial_in = 1'b1; tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_data",  {24'd0, data_out}, 32'h0);
        chk("arst_perr",  {31'd0, parity_err}, 32'd0);
        chk("arst_busy",  {31'd0, busy}, 32'd0);
        chk("arst_valid", {31'd0, valid}, 32'd0);
        serial_in = 1'b1;
        #1;
        rst = 1'b1;
        tick();
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        chk("f5_valid", {31'd0, valid}, 32'd1);
        chk("f5_data",  {24'd0, data_out}, 32'h5A);
        chk("f5_perr",  {31'd0, parity_err}, 32'd0);
        idle_cycle();

        // Back-to-back 0x12 then 0xFE, no idle bit between
        send_frame(8'h12, 1'b0, 1'b1, 1'b0);
        chk("b1_valid", {31'd0, valid}, 32'd1);
        chk("b1_data",  {24'd0, data_out}, 32'h12);
        send_frame(8'hFE, 1'b1, 1'b1, 1'b0);
        chk("b2_valid", {31'd0, valid}, 32'd1);
        chk("b2_data",  {24'd0, data_out}, 32'hFE);
        chk("b2_perr",  {31'd0, parity_err}, 32'd0);
        idle_cycle();
        chk("b2_valid_drop", {31'd0, valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
